cordic_seq_ctrl: RTL

- Iterative CORDIC rotation controller for the shape-render pipeline.
- Accepts one request per transaction (size, binary angle, sideband tag) over a valid/ready handshake.
- Applies the 155/256 gain prescale and a quadrant pre-rotation, then runs ITER micro-rotations on one shared shift-add datapath.
- Returns size·cos and size·sin in the 19-bit signed cord format. It replaces the unrolled stage chain where area matters.

---
 rtl/cordic_pkg.sv | 43 ++++
 rtl/cordic_microrot.sv | 41 ++++
 rtl/cordic_seq_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, FSM state type and arctangent table for the sequential
// CORDIC rotation controller.
//   CORD_W   : width of the signed cord (x/y) format
//   ANG_W    : width of the binary angle (512 units per turn)
//   Z_W      : width of the signed residual-angle register
//   GAIN_NUM : numerator of the 155/256 prescale that cancels CORDIC gain
//   atan_lut : atan(2^-i) in units of 2^-8 of 1/512 turn
package cordic_pkg;

  localparam int unsigned CORD_W   = 19;
  localparam int unsigned ANG_W    = 9;
  localparam int unsigned Z_W      = 17;
  localparam int unsigned GAIN_NUM = 155;
  localparam int unsigned SIZE_W   = 7;
  localparam int unsigned BASE_W   = 15;

  typedef enum logic [1:0] {
    IDLE,
    ROT,
    DONE
  } state_t;

  function automatic logic signed [Z_W-1:0] atan_lut(input logic [3:0] idx);
    logic signed [Z_W-1:0] v;
    case (idx)
      4'd0:    v = 17'sd16384;
      4'd1:    v = 17'sd9672;
      4'd2:    v = 17'sd5110;
      4'd3:    v = 17'sd2594;
      4'd4:    v = 17'sd1302;
      4'd5:    v = 17'sd652;
      4'd6:    v = 17'sd326;
      4'd7:    v = 17'sd163;
      4'd8:    v = 17'sd81;
      4'd9:    v = 17'sd41;
      4'd10:   v = 17'sd20;
      4'd11:   v = 17'sd10;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_microrot.sv
// One CORDIC micro-rotation (combinational), shared by every iteration.
// Rotation direction follows the sign of the residual angle z.
//   i             : iteration index (shift amount and table index)
//   x_in/y_in     : current vector, signed CORD_W
//   z_in          : current residual angle, signed Z_W
//   x_out/y_out   : rotated vector
//   z_out         : updated residual angle
module cordic_microrot
  import cordic_pkg::*;
(
  input  logic        [3:0]        i,
  input  logic signed [CORD_W-1:0] x_in,
  input  logic signed [CORD_W-1:0] y_in,
  input  logic signed [Z_W-1:0]    z_in,
  output logic signed [CORD_W-1:0] x_out,
  output logic signed [CORD_W-1:0] y_out,
  output logic signed [Z_W-1:0]    z_out
);

  logic signed [CORD_W-1:0] x_sh;
  logic signed [CORD_W-1:0] y_sh;
  logic signed [Z_W-1:0]    atan_i;

  always_comb begin
    x_sh   = x_in >>> i;
    y_sh   = y_in >>> i;
    atan_i = atan_lut(i);
    if (z_in[Z_W-1]) begin
      // d = -1
      x_out = x_in + y_sh;
      y_out = y_in - x_sh;
      z_out = z_in + atan_i;
    end else begin
      // d = +1
      x_out = x_in - y_sh;
      y_out = y_in + x_sh;
      z_out = z_in - atan_i;
    end
  end

endmodule

// File: rtl/cordic_seq_ctrl.sv
// Iterative CORDIC rotation controller. Accepts (size, angle, tag), applies
// the 155/256 gain prescale and a quadrant pre-rotation, then runs ITER
// micro-rotations on one shared datapath and returns size*cos / size*sin.
//   clk, reset          : clock, asynchronous active-low reset
//   in_valid/in_ready   : request handshake (ready only in IDLE)
//   in_size             : unsigned shape size
//   in_angle            : signed binary angle, 512 units per turn
//   in_tag              : sideband returned unchanged with the result
//   out_valid/out_ready : result handshake
//   out_cos/out_sin     : signed CORD_W results, ~(size<<8)*cos/sin(angle)
//   out_tag             : tag of the request
//   busy                : controller not in IDLE
module cordic_seq_ctrl
  import cordic_pkg::*;
#(
  parameter int unsigned ITER  = 12,
  parameter int unsigned TAG_W = 40,
  parameter int unsigned ZF    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SIZE_W-1:0]        in_size,
  input  logic [ANG_W-1:0]         in_angle,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [CORD_W-1:0] out_cos,
  output logic signed [CORD_W-1:0] out_sin,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     busy
);

  localparam int unsigned FINE_W = ANG_W - 2;
  localparam int unsigned PROD_W = BASE_W + 8;
  localparam logic [3:0]  I_LAST = 4'(ITER - 1);

  state_t state, state_n;

  logic signed [CORD_W-1:0] x_q, y_q, x_nx, y_nx, x0, y0, x0_pos;
  logic signed [Z_W-1:0]    z_q, z_nx, z0;
  logic [3:0]               i_q;
  logic [TAG_W-1:0]         tag_q;

  logic [FINE_W-1:0] fine;
  logic [1:0]        quad;
  logic              fine_zero;
  logic              accept;
  logic [BASE_W-1:0] base;
  logic [BASE_W-1:0] x0_mag;
  logic [PROD_W-1:0] prod;

  assign fine      = in_angle[FINE_W-1:0];
  assign quad      = in_angle[ANG_W-1 -: 2];
  assign fine_zero = (fine == '0);
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // The x/y/tag registers double as the result registers; their reset
  // value provides the zeroed outputs.
  assign out_cos = x_q;
  assign out_sin = y_q;
  assign out_tag = tag_q;

  // Prescale and quadrant pre-rotation of the incoming request. A zero
  // fine angle skips rotation entirely, so no gain compensation is applied.
  always_comb begin
    base   = {in_size, 8'd0};
    prod   = PROD_W'(base) * PROD_W'(GAIN_NUM);
    x0_mag = fine_zero ? base : prod[PROD_W-1:8];
    x0_pos = {{(CORD_W-BASE_W){1'b0}}, x0_mag};
    x0     = '0;
    y0     = '0;
    case (quad)
      2'b00:   x0 = x0_pos;
      2'b01:   y0 = x0_pos;
      2'b10:   x0 = -x0_pos;
      default: y0 = -x0_pos;
    endcase
    z0 = Z_W'(fine) << ZF;
  end

  cordic_microrot u_microrot (
    .i     (i_q),
    .x_in  (x_q),
    .y_in  (y_q),
    .z_in  (z_q),
    .x_out (x_nx),
    .y_out (y_nx),
    .z_out (z_nx)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = fine_zero ? DONE : ROT;
      ROT:     if (i_q == I_LAST) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      i_q   <= '0;
      tag_q <= '0;
    end else if (accept) begin
      x_q   <= x0;
      y_q   <= y0;
      z_q   <= z0;
      i_q   <= '0;
      tag_q <= in_tag;
    end else if (state == ROT) begin
      x_q <= x_nx;
      y_q <= y_nx;
      z_q <= z_nx;
      i_q <= i_q + 4'd1;
    end
  end

endmodule
